inst_encoder: RTL

Streaming RV32I instruction encoder: the inverse of the CPU's field decoder. Accepts instruction fields (5-bit opcode inst[6:2], func3, func7 bit inst[30], rs1/rs2/rd indices, 32-bit immediate) over a valid/ready handshake. Packs them into a 32-bit instruction word and emits it with a sequential word address through a 2-entry output buffer. Sits in the test/bring-up path ahead of instruction-memory load, so programs are built from decoded-field descriptions.

---
 rtl/inst_encoder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// RV32I field-to-word encoder: packs decoded instruction fields into a 32-bit word,
// tags it with a sequential byte address and queues it in a 2-entry output buffer.
module inst_encoder #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_func3,
    input  logic              in_func7,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              err_illegal,
    output logic              done
);

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);
    localparam logic [31:0]       NOP   = 32'h0000_0013;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    logic [31:0]       enc_inst;
    logic              enc_illegal;
    logic [6:0]        enc_op;

    logic [31:0]       fifo_inst_q [2];
    logic [31:0]       fifo_inst_d [2];
    logic [ADDR_W-1:0] fifo_addr_q [2];
    logic [ADDR_W-1:0] fifo_addr_d [2];
    logic              fifo_last_q [2];
    logic              fifo_last_d [2];

    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              push;
    logic              pop;
    logic              head_sel;

    // Field packing; unused fields of a format never reach the word.
    always_comb begin
        enc_op      = {in_opcode, 2'b11};
        enc_inst    = NOP;
        enc_illegal = 1'b0;
        case (in_opcode)
            OP_REG: begin
                enc_inst = {1'b0, in_func7, 5'b00000, in_rs2, in_rs1, in_func3, in_rd, enc_op};
            end
            OP_IMM: begin
                if (in_func3 == 3'b001 || in_func3 == 3'b101) begin
                    enc_inst = {1'b0, in_func7, 5'b00000, in_imm[4:0], in_rs1, in_func3, in_rd, enc_op};
                end else begin
                    enc_inst = {in_imm[11:0], in_rs1, in_func3, in_rd, enc_op};
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                enc_inst = {in_imm[11:0], in_rs1, in_func3, in_rd, enc_op};
            end
            OP_STORE: begin
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], enc_op};
            end
            OP_BRANCH: begin
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                            in_imm[4:1], in_imm[11], enc_op};
            end
            OP_LUI, OP_AUIPC: begin
                enc_inst = {in_imm[31:12], in_rd, enc_op};
            end
            OP_JAL: begin
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, enc_op};
            end
            default: begin
                enc_inst    = NOP;
                enc_illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = (count_q < 2'd2);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // When empty, the head slot is the one just vacated, so out_* keep the last popped word.
    assign head_sel    = (count_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_inst    = fifo_inst_q[head_sel];
    assign out_addr    = fifo_addr_q[head_sel];
    assign out_last    = fifo_last_q[head_sel];
    assign err_illegal = err_q;
    assign done        = done_q;

    always_comb begin
        fifo_inst_d = fifo_inst_q;
        fifo_addr_d = fifo_addr_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        err_d       = err_q;
        done_d      = done_q;

        if (push) begin
            fifo_inst_d[wr_ptr_q] = enc_inst;
            fifo_addr_d[wr_ptr_q] = addr_q;
            fifo_last_d[wr_ptr_q] = in_last;
            wr_ptr_d              = ~wr_ptr_q;
            addr_d                = in_last ? BASE : addr_q + STEP;
            err_d                 = err_q | enc_illegal;
            done_d                = 1'b0;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (out_last) begin
                done_d = 1'b1;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fifo_inst_q[gi] <= '0;
                    fifo_addr_q[gi] <= '0;
                    fifo_last_q[gi] <= 1'b0;
                end else begin
                    fifo_inst_q[gi] <= fifo_inst_d[gi];
                    fifo_addr_q[gi] <= fifo_addr_d[gi];
                    fifo_last_q[gi] <= fifo_last_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            addr_q   <= BASE;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

endmodule
